idct4_pipe: RTL and testbench
=============================

IDCT4_PIPE -- requirements
Module: idct4_pipe

Interface
REQ-001 Parameter DATA_W, default 16: signed width of each input coefficient.
REQ-002 Parameter OUT_W, default 16: signed width of each output residual.
REQ-003 Parameter SHIFT, default 7: arithmetic right-shift applied after the butterfly; legal range 1..20.
REQ-004 Parameter CLIP_EN, default 1: 1 = saturate to OUT_W; 0 = truncate to the OUT_W LSBs.
REQ-005 Port list, one per line:
  clk  input  1  rising-edge clock, the only clock.
  reset  input  1  asynchronous, active-low reset; asserted when 0.
  in_valid  input  1  input vector valid.
  in_ready  output  1  block accepts a vector this cycle.
  s0..s3  input  DATA_W each  signed coefficient column, s0 = DC.
  out_valid  output  1  output vector valid.
  out_ready  input  1  downstream accepts a vector this cycle.
  y0..y3  output  OUT_W each  signed residual row.
  sat  output  4  per-lane saturation flag, bit k for yk, aligned with y.

Function
REQ-006 The block SHALL accept a vector when in_valid && in_ready, and SHALL deliver a vector when out_valid && out_ready.
REQ-007 The datapath SHALL be 3 registered stages: S1 products, S2 butterfly, S3 round/clip. Each stage SHALL carry its own valid bit.
REQ-008 Latency SHALL be exactly 3 cycles from acceptance to out_valid when there is no backpressure. Throughput SHALL be one vector per cycle.
REQ-009 S1 SHALL register p0=64*s0, p2=64*s2, a=83*s1, b=36*s1, c=36*s3, d=83*s3, each DATA_W+8 bits signed.
REQ-010 S2 SHALL register E0=p0+p2, E1=p0-p2, O0=a+c, O1=b-d, each DATA_W+10 bits signed.
REQ-011 S3 SHALL compute r0=E0+O0, r1=E1+O1, r2=E1-O1, r3=E0-O0 at full width with no overflow.
REQ-012 S3 SHALL then form zk=(rk + 2^(SHIFT-1)) >>> SHIFT (arithmetic, floor) and register yk.
REQ-013 With CLIP_EN=1: if zk > 2^(OUT_W-1)-1, yk SHALL be 2^(OUT_W-1)-1 and sat[k] SHALL be 1. If zk < -2^(OUT_W-1), yk SHALL be -2^(OUT_W-1) and sat[k] SHALL be 1. Otherwise yk=zk and sat[k]=0.
REQ-014 With CLIP_EN=0: yk SHALL be zk[OUT_W-1:0] and sat SHALL be 0.
REQ-015 Global advance enable SHALL be en = out_ready || !out_valid. All stage registers and valid bits SHALL update only when en=1.
REQ-016 in_ready SHALL equal en, combinationally.
REQ-017 While out_valid=1 and out_ready=0, y, sat and out_valid SHALL hold stable, and no input SHALL be accepted.
REQ-018 Bubbles (in_valid=0 while en=1) SHALL propagate as cleared valid bits. Data registers of invalid stages are don't-care, but y/sat SHALL change only when a valid vector enters S3.
REQ-019 Accepting a vector and delivering one in the same cycle SHALL be supported with no loss or duplication.
REQ-020 Vectors SHALL leave in acceptance order.

Reset
REQ-021 While reset=0, all valid bits, y0..y3 and sat SHALL be 0. Consequently out_valid=0 and in_ready=1 during reset.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight vectors. After release, the first output SHALL be the first vector accepted after release.
REQ-023 Reset release SHALL take effect on the first rising clk after reset goes 1. No output SHALL be produced before 3 accept-to-output cycles.

Verification
REQ-024 DC only, defaults, out_ready=1: s=(64,0,0,0) accepted at cycle N -> cycle N+3 out_valid=1, y=(32,32,32,32), sat=0.
REQ-025 Odd basis: s=(0,64,0,0) -> y=(42,18,-18,-41), sat=0. This checks floor rounding on negative values.
REQ-026 Saturation: s=(32767,32767,32767,32767), CLIP_EN=1 -> y0=32767, sat[0]=1, other lanes checked against the REQ-011..013 model. With CLIP_EN=0: y0 = low 16 bits of 63230, sat=0.
REQ-027 Backpressure: stream 8 random vectors with out_ready toggling on a pseudo-random pattern -> the 8 outputs match the reference model, in order, none dropped or duplicated. y stays stable while stalled. in_ready=0 exactly when out_valid && !out_ready.
REQ-028 Reset mid-stream: accept 2 vectors, assert reset=0 for one cycle while both are in flight -> out_valid=0 and y=0 immediately. After release, only newly accepted vectors appear.
REQ-029 Parameter sweep: DATA_W=9/OUT_W=9/SHIFT=12 and DATA_W=16/OUT_W=16/SHIFT=7 -> 1000 random vectors per configuration match the bit-exact model.

Source files
------------

// File: rtl/idct4_pipe_if.sv
// Stream bundle for idct4_pipe: input coefficient vector handshake and
// output residual row handshake.
//   in_valid/in_ready/s0..s3       : input vector (s0 = DC coefficient)
//   out_valid/out_ready/y0..y3/sat : output residual row plus per-lane saturation
// slave  : view of the transform block
// master : view of the producer/consumer around it
interface idct4_pipe_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] s0;
    logic signed [DATA_W-1:0] s1;
    logic signed [DATA_W-1:0] s2;
    logic signed [DATA_W-1:0] s3;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  y0;
    logic signed [OUT_W-1:0]  y1;
    logic signed [OUT_W-1:0]  y2;
    logic signed [OUT_W-1:0]  y3;
    logic [3:0]               sat;

    modport slave (
        input  in_valid, s0, s1, s2, s3, out_ready,
        output in_ready, out_valid, y0, y1, y2, y3, sat
    );

    modport master (
        output in_valid, s0, s1, s2, s3, out_ready,
        input  in_ready, out_valid, y0, y1, y2, y3, sat
    );
endinterface

// File: rtl/idct4_pipe.sv
// 4-point inverse DCT (HEVC-style even/odd butterfly), 3 registered stages:
// S1 constant products, S2 even/odd butterfly, S3 recombine + round + clip.
// A single global enable stalls the whole pipe under output backpressure.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : idct4_pipe_if.slave (input vector handshake, output row handshake)
module idct4_pipe #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned SHIFT   = 7,
    parameter int unsigned CLIP_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    idct4_pipe_if.slave bus
);
    localparam int unsigned PW = DATA_W + 8;
    localparam int unsigned EW = DATA_W + 10;
    // Recombine width: one guard bit over the butterfly sums, and wide enough
    // that the rounding constant itself stays positive.
    localparam int unsigned RW = (DATA_W + 12 > SHIFT + 2) ? DATA_W + 12 : SHIFT + 2;
    localparam int unsigned CW = (RW > OUT_W) ? RW : OUT_W + 1;

    localparam logic signed [PW-1:0] K64   = PW'(64);
    localparam logic signed [PW-1:0] K83   = PW'(83);
    localparam logic signed [PW-1:0] K36   = PW'(36);
    localparam logic signed [RW-1:0] RND   = RW'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [CW-1:0] Y_MAX = CW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [CW-1:0] Y_MIN = CW'(-(64'sd1 <<< (OUT_W - 1)));

    logic en;
    logic v1_q, v2_q, v3_q;

    logic signed [PW-1:0] p0_d, p2_d, a_d, b_d, c_d, d_d;
    logic signed [PW-1:0] p0_q, p2_q, a_q, b_q, c_q, d_q;
    logic signed [EW-1:0] e0_d, e1_d, o0_d, o1_d;
    logic signed [EW-1:0] e0_q, e1_q, o0_q, o1_q;
    logic signed [RW-1:0] r [4];
    logic signed [RW-1:0] z;
    logic signed [CW-1:0] zx;
    logic signed [OUT_W-1:0] y_d [4];
    logic signed [OUT_W-1:0] y_q [4];
    logic [3:0] sat_d, sat_q;

    // Whole pipe advances when the output slot is free or being drained.
    assign en           = bus.out_ready || !v3_q;
    assign bus.in_ready = en;

    // S1: constant products
    always_comb begin
        p0_d = PW'(bus.s0) * K64;
        p2_d = PW'(bus.s2) * K64;
        a_d  = PW'(bus.s1) * K83;
        b_d  = PW'(bus.s1) * K36;
        c_d  = PW'(bus.s3) * K36;
        d_d  = PW'(bus.s3) * K83;
    end

    // S2: even/odd butterfly
    always_comb begin
        e0_d = EW'(p0_q) + EW'(p2_q);
        e1_d = EW'(p0_q) - EW'(p2_q);
        o0_d = EW'(a_q) + EW'(c_q);
        o1_d = EW'(b_q) - EW'(d_q);
    end

    // S3: recombine, round-half-up with floor shift, then saturate or wrap
    always_comb begin
        sat_d = '0;
        z     = '0;
        zx    = '0;
        for (int k = 0; k < 4; k++) begin
            y_d[k] = '0;
        end
        r[0] = RW'(e0_q) + RW'(o0_q);
        r[1] = RW'(e1_q) + RW'(o1_q);
        r[2] = RW'(e1_q) - RW'(o1_q);
        r[3] = RW'(e0_q) - RW'(o0_q);
        for (int k = 0; k < 4; k++) begin
            z  = (r[k] + RND) >>> SHIFT;
            zx = CW'(z);
            if (CLIP_EN != 0 && zx > Y_MAX) begin
                y_d[k]   = Y_MAX[OUT_W-1:0];
                sat_d[k] = 1'b1;
            end else if (CLIP_EN != 0 && zx < Y_MIN) begin
                y_d[k]   = Y_MIN[OUT_W-1:0];
                sat_d[k] = 1'b1;
            end else begin
                y_d[k] = zx[OUT_W-1:0];
            end
        end
    end

    // Stage registers; data only loads behind a valid so y/sat hold across bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            p0_q  <= '0;
            p2_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            e0_q  <= '0;
            e1_q  <= '0;
            o0_q  <= '0;
            o1_q  <= '0;
            sat_q <= '0;
            for (int k = 0; k < 4; k++) begin
                y_q[k] <= '0;
            end
        end else if (en) begin
            v1_q <= bus.in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (bus.in_valid) begin
                p0_q <= p0_d;
                p2_q <= p2_d;
                a_q  <= a_d;
                b_q  <= b_d;
                c_q  <= c_d;
                d_q  <= d_d;
            end
            if (v1_q) begin
                e0_q <= e0_d;
                e1_q <= e1_d;
                o0_q <= o0_d;
                o1_q <= o1_d;
            end
            if (v2_q) begin
                sat_q <= sat_d;
                for (int k = 0; k < 4; k++) begin
                    y_q[k] <= y_d[k];
                end
            end
        end
    end

    assign bus.out_valid = v3_q;
    assign bus.y0        = y_q[0];
    assign bus.y1        = y_q[1];
    assign bus.y2        = y_q[2];
    assign bus.y3        = y_q[3];
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_idct4_pipe.sv
// Scoreboard bench for idct4_pipe. Three instances: A (16/16/7 saturating),
// B (same stream as A, wrapping), C (9/9/12 saturating). Expected rows come
// from a matrix-form reference model and are queued at acceptance; monitors
// pop and compare whenever a row is delivered.
module tb_idct4_pipe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    idct4_pipe_if #(.DATA_W(16), .OUT_W(16)) ifa ();
    idct4_pipe_if #(.DATA_W(16), .OUT_W(16)) ifb ();
    idct4_pipe_if #(.DATA_W(9),  .OUT_W(9))  ifc ();

    idct4_pipe #(.DATA_W(16), .OUT_W(16), .SHIFT(7), .CLIP_EN(1))
        u_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    idct4_pipe #(.DATA_W(16), .OUT_W(16), .SHIFT(7), .CLIP_EN(0))
        u_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    idct4_pipe #(.DATA_W(9), .OUT_W(9), .SHIFT(12), .CLIP_EN(1))
        u_c (.clk(clk), .reset(reset), .bus(ifc.slave));

    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.s0        = ifa.s0;
    assign ifb.s1        = ifa.s1;
    assign ifb.s2        = ifa.s2;
    assign ifb.s3        = ifa.s3;
    assign ifb.out_ready = ifa.out_ready;

    typedef struct packed {
        logic [3:0][63:0] y;
        logic [3:0]       sat;
        logic [31:0]      cyc;
        logic             lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit lat_mode = 1'b0;
    bit bp_a = 1'b0;
    bit bp_c = 1'b0;

    int coef [4][4] = '{'{64,  83,  64,  36},
                        '{64,  36, -64, -83},
                        '{64, -36, -64,  83},
                        '{64, -83,  64, -36}};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    endtask

    // Reference: y = round(C * s / 2^sh), then saturate or wrap to ow bits.
    function automatic exp_t model(input longint s[4], input int ow, input int sh, input bit clip);
        exp_t   e;
        longint one = 1;
        longint r, z, hi, lo, t;
        e  = '0;
        hi = (one <<< (ow - 1)) - 1;
        lo = -(one <<< (ow - 1));
        for (int k = 0; k < 4; k++) begin
            r = 0;
            for (int j = 0; j < 4; j++) r += longint'(coef[k][j]) * s[j];
            z = (r + (one <<< (sh - 1))) >>> sh;
            if (clip && z > hi) begin
                t = hi; e.sat[k] = 1'b1;
            end else if (clip && z < lo) begin
                t = lo; e.sat[k] = 1'b1;
            end else if (clip) begin
                t = z;
            end else begin
                t = z & ((one <<< ow) - 1);
                if (t > hi) t -= (one <<< ow);
            end
            e.y[k] = 64'(t);
        end
        return e;
    endfunction

    function automatic longint rnd_val(input int dw);
        longint one = 1;
        longint hi = (one <<< (dw - 1)) - 1;
        longint lo = -(hi + 1);
        case ($urandom_range(0, 7))
            0:       return hi;
            1:       return lo;
            default: return longint'($urandom_range(0, 32'((one <<< dw) - 1))) + lo;
        endcase
    endfunction

    task automatic cmp_vec(input string tag, input exp_t e, input longint act[4], input logic [3:0] s);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_y%0d", tag, k), act[k], $signed(e.y[k]));
        chk({tag, "_sat"}, longint'(s), longint'(e.sat));
        if (e.lat) chk({tag, "_latency"}, longint'(cyc) - longint'(e.cyc), 3);
    endtask

    // Output-ready pattern generators
    initial begin
        ifa.out_ready = 1'b1;
        ifc.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            ifa.out_ready = bp_a ? ($urandom_range(0, 2) != 0) : 1'b1;
            ifc.out_ready = bp_c ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitors: scoreboard pop, stall stability, in_ready rule
    bit            stall_prev = 1'b0;
    longint        held_y [4];
    logic [3:0]    held_sat;

    always @(negedge clk) begin
        longint act[4];
        exp_t   e;
        if (reset === 1'b1) begin
            act[0] = ifa.y0; act[1] = ifa.y1; act[2] = ifa.y2; act[3] = ifa.y3;
            if (stall_prev) begin
                chk("A_stall_valid", longint'(ifa.out_valid), 1);
                for (int k = 0; k < 4; k++) chk($sformatf("A_stall_y%0d", k), act[k], held_y[k]);
                chk("A_stall_sat", longint'(ifa.sat), longint'(held_sat));
            end
            chk("A_in_ready", longint'(ifa.in_ready), longint'(!(ifa.out_valid && !ifa.out_ready)));
            stall_prev = ifa.out_valid && !ifa.out_ready;
            held_y     = act;
            held_sat   = ifa.sat;
            if (ifa.out_valid && ifa.out_ready) begin
                if (qa.size() == 0) chk("A_unexpected_output", 1, 0);
                else begin e = qa.pop_front(); cmp_vec("A", e, act, ifa.sat); end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    always @(negedge clk) begin
        longint act[4];
        exp_t   e;
        if (reset === 1'b1 && ifb.out_valid && ifb.out_ready) begin
            act[0] = ifb.y0; act[1] = ifb.y1; act[2] = ifb.y2; act[3] = ifb.y3;
            if (qb.size() == 0) chk("B_unexpected_output", 1, 0);
            else begin e = qb.pop_front(); cmp_vec("B", e, act, ifb.sat); end
        end
    end

    always @(negedge clk) begin
        longint act[4];
        exp_t   e;
        if (reset === 1'b1) begin
            chk("C_in_ready", longint'(ifc.in_ready), longint'(!(ifc.out_valid && !ifc.out_ready)));
            if (ifc.out_valid && ifc.out_ready) begin
                act[0] = ifc.y0; act[1] = ifc.y1; act[2] = ifc.y2; act[3] = ifc.y3;
                if (qc.size() == 0) chk("C_unexpected_output", 1, 0);
                else begin e = qc.pop_front(); cmp_vec("C", e, act, ifc.sat); end
            end
        end
    end

    // Drivers: hold the vector until accepted, queue expectations at acceptance.
    task automatic drive_ab(input longint s[4], input exp_t ea, input exp_t eb);
        bit done = 1'b0;
        ifa.in_valid = 1'b1;
        ifa.s0 = 16'(s[0]); ifa.s1 = 16'(s[1]); ifa.s2 = 16'(s[2]); ifa.s3 = 16'(s[3]);
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clk);
            if (ifa.in_ready) begin
                ea.cyc = 32'(cyc); eb.cyc = 32'(cyc);
                ea.lat = lat_mode; eb.lat = lat_mode;
                qa.push_back(ea); qb.push_back(eb);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("A_accept_timeout", 0, 1);
    endtask

    task automatic drive_c(input longint s[4]);
        bit   done = 1'b0;
        exp_t ec = model(s, 9, 12, 1'b1);
        ifc.in_valid = 1'b1;
        ifc.s0 = 9'(s[0]); ifc.s1 = 9'(s[1]); ifc.s2 = 9'(s[2]); ifc.s3 = 9'(s[3]);
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                ec.cyc = 32'(cyc); ec.lat = 1'b0;
                qc.push_back(ec);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("C_accept_timeout", 0, 1);
    endtask

    task automatic idle_ab();
        ifa.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rnd_ab(input int n);
        longint s[4];
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) s[j] = rnd_val(16);
            drive_ab(s, model(s, 16, 7, 1'b1), model(s, 16, 7, 1'b0));
            if ($urandom_range(0, 3) == 0) idle_ab();
        end
        ifa.in_valid = 1'b0;
    endtask

    task automatic rnd_c(input int n);
        longint s[4];
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) s[j] = rnd_val(9);
            drive_c(s);
            if ($urandom_range(0, 3) == 0) begin
                ifc.in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 5000 && (qa.size() != 0 || qb.size() != 0 || qc.size() != 0); i++)
            @(negedge clk);
        chk("A_drain_left", longint'(qa.size()), 0);
        chk("B_drain_left", longint'(qb.size()), 0);
        chk("C_drain_left", longint'(qc.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_A_out_valid"}, longint'(ifa.out_valid), 0);
        chk({tag, "_A_in_ready"},  longint'(ifa.in_ready), 1);
        chk({tag, "_A_y0"},        longint'(ifa.y0), 0);
        chk({tag, "_A_y3"},        longint'(ifa.y3), 0);
        chk({tag, "_A_sat"},       longint'(ifa.sat), 0);
        chk({tag, "_C_out_valid"}, longint'(ifc.out_valid), 0);
        chk({tag, "_C_y1"},        longint'(ifc.y1), 0);
    endtask

    initial begin
        longint s[4];
        exp_t   ea, eb;

        reset = 1'b1;
        ifa.in_valid = 1'b0; ifa.s0 = '0; ifa.s1 = '0; ifa.s2 = '0; ifa.s3 = '0;
        ifc.in_valid = 1'b0; ifc.s0 = '0; ifc.s1 = '0; ifc.s2 = '0; ifc.s3 = '0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // Directed vectors with known answers, no backpressure, latency checked
        lat_mode = 1'b1;
        s = '{64, 0, 0, 0};
        ea = '0; ea.y = {64'sd32, 64'sd32, 64'sd32, 64'sd32};
        drive_ab(s, ea, ea);
        idle_ab();
        s = '{0, 64, 0, 0};
        ea = '0; ea.y = {-64'sd41, -64'sd18, 64'sd18, 64'sd42};
        drive_ab(s, ea, ea);
        s = '{32767, 32767, 32767, 32767};
        ea = model(s, 16, 7, 1'b1); ea.y[0] = 64'(32767); ea.sat[0] = 1'b1;
        eb = model(s, 16, 7, 1'b0); eb.y[0] = 64'(-2306); eb.sat = '0;
        drive_ab(s, ea, eb);
        s = '{-32768, -32768, -32768, -32768};
        drive_ab(s, model(s, 16, 7, 1'b1), model(s, 16, 7, 1'b0));
        s = '{-64, 0, 0, 0};
        ea = '0; ea.y = {-64'sd32, -64'sd32, -64'sd32, -64'sd32};
        drive_ab(s, ea, ea);
        idle_ab();
        drain();
        lat_mode = 1'b0;

        // Eight random vectors under pseudo-random backpressure
        bp_a = 1'b1;
        rnd_ab(8);
        drain();
        bp_a = 1'b0;
        @(posedge clk); #1;

        // Reset while two vectors are in flight
        s = '{100, -200, 300, -400};
        drive_ab(s, model(s, 16, 7, 1'b1), model(s, 16, 7, 1'b0));
        s = '{-1000, 500, 0, 7};
        drive_ab(s, model(s, 16, 7, 1'b1), model(s, 16, 7, 1'b0));
        ifa.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk_reset_state("midreset");
        qa.delete(); qb.delete(); qc.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_A_out_valid", longint'(ifa.out_valid), 0);
        @(posedge clk); #1;
        lat_mode = 1'b1;
        rnd_ab(3);
        drain();
        lat_mode = 1'b0;

        // Parameter sweep: 1000 vectors per configuration, concurrent streams
        bp_a = 1'b1;
        bp_c = 1'b1;
        fork
            rnd_ab(1000);
            rnd_c(1000);
        join
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
